// File: rtl/pattern_match_ctrl_if.sv
// pattern_match_ctrl_if: host/config and serial-line signals of the pattern run-controller
interface pattern_match_ctrl_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             cfg_we_i;
   logic [PAT_W-1:0] cfg_pattern_i;
   logic             start_i;
   logic             stop_i;
   logic             din_i;
   logic             tick_o;
   logic             busy_o;
   logic             match_o;
   logic             timeout_o;
   logic [CNT_W-1:0] match_cnt_o;
   modport master (
      output cfg_we_i, cfg_pattern_i, start_i, stop_i, din_i,
      input  tick_o, busy_o, match_o, timeout_o, match_cnt_o
   );
   modport slave (
      input  cfg_we_i, cfg_pattern_i, start_i, stop_i, din_i,
      output tick_o, busy_o, match_o, timeout_o, match_cnt_o
   );
endinterface

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl: tick-sampled serial pattern hunter with match counter and idle timeout.
// Define PMC_OVERLAP_EN to keep the shift history across a match so overlapping matches count.
module pattern_match_ctrl #(
   parameter int               TICK_DIV    = 2_500_000,
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] PAT_RST     = PAT_W'(4'b1101),
   parameter int               MAX_SAMPLES = 64,
   parameter int               CNT_W       = 8
) (
   input logic                 clk,
   input logic                 rst,
   pattern_match_ctrl_if.slave bus
);
   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam int SC_W   = $clog2(MAX_SAMPLES + 2);
   typedef enum logic [1:0] {IDLE, HUNT, HIT, TMO} state_e;
   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [PAT_W-1:0]  pattern_q, pattern_d, shreg_q, shreg_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [SC_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
   logic              sample_q;
   logic              busy, tick, match_term, tmo_term, idle_clr, hit_entry, sh_clr;
   always_comb begin
      busy       = state_q == HUNT || state_q == HIT;
      tick       = busy && div_q == DIV_W'(TICK_DIV - 1);
      match_term = sample_q && fill_q == FILL_W'(PAT_W) && shreg_q == pattern_q;
      tmo_term   = sample_q && MAX_SAMPLES != 0 && sample_cnt_q == SC_W'(MAX_SAMPLES);
   end
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // stop overrides everything, so a match pending in the same cycle is dropped
   always_comb begin
      state_d = state_q;
      if (bus.stop_i) state_d = IDLE;
      else case (state_q)
         IDLE, TMO: state_d = bus.start_i ? HUNT : state_q;
         HUNT:      state_d = match_term ? HIT : tmo_term ? TMO : HUNT;
         default:   state_d = HUNT;
      endcase
   end
   always_comb begin
      bus.tick_o      = tick;
      bus.busy_o      = busy;
      bus.match_o     = state_q == HIT;
      bus.timeout_o   = state_q == TMO;
      bus.match_cnt_o = match_cnt_q;
   end
   always_comb begin
      idle_clr     = state_q == IDLE || state_q == TMO;
      hit_entry    = state_q == HUNT && state_d == HIT;
`ifdef PMC_OVERLAP_EN
      sh_clr       = idle_clr;
`else
      sh_clr       = idle_clr || hit_entry;
`endif
      div_d        = (!busy || tick) ? '0 : div_q + 1'b1;
      shreg_d      = sh_clr ? '0 : tick ? {shreg_q[PAT_W-2:0], bus.din_i} : shreg_q;
      fill_d       = sh_clr ? '0 : (tick && fill_q != FILL_W'(PAT_W)) ? fill_q + 1'b1 : fill_q;
      sample_cnt_d = (idle_clr || hit_entry) ? '0 :
                     (tick && sample_cnt_q != '1) ? sample_cnt_q + 1'b1 : sample_cnt_q;
      // count survives TMO for inspection and is cleared only by a fresh start
      match_cnt_d  = (state_q == IDLE || (state_q == TMO && state_d == HUNT)) ? '0 :
                     (hit_entry && match_cnt_q != '1) ? match_cnt_q + 1'b1 : match_cnt_q;
      pattern_d    = (state_q == IDLE && bus.cfg_we_i) ? bus.cfg_pattern_i : pattern_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         pattern_q    <= PAT_RST;
         shreg_q      <= '0;
         fill_q       <= '0;
         sample_cnt_q <= '0;
         match_cnt_q  <= '0;
         sample_q     <= 1'b0;
      end else begin
         div_q        <= div_d;
         pattern_q    <= pattern_d;
         shreg_q      <= shreg_d;
         fill_q       <= fill_d;
         sample_cnt_q <= sample_cnt_d;
         match_cnt_q  <= match_cnt_d;
         sample_q     <= tick;
      end
   end
endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb_pattern_match_ctrl: directed and random bit streams checked against a sample-history model.
module tb_pattern_match_ctrl;
   localparam int TICK_DIV = 4;
   localparam int PAT_W    = 4;
   localparam int MAX_S    = 8;
   localparam int CNT_W    = 2;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PMC_OVERLAP_EN
   localparam int OVL_CNT = 2;
`else
   localparam int OVL_CNT = 1;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   pattern_match_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
   pattern_match_ctrl #(
      .TICK_DIV(TICK_DIV), .PAT_W(PAT_W), .PAT_RST(4'b1101),
      .MAX_SAMPLES(MAX_S), .CNT_W(CNT_W)
   ) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic             hist[$];
   logic [PAT_W-1:0] m_pat = 4'b1101;
   int               m_cnt = 0;
   int               m_sc = 0;
   bit               fresh = 1'b0;
   bit               last_tmo = 1'b0;
   task automatic step();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic model_match();
      logic [PAT_W-1:0] v = '0;
      if (hist.size() < PAT_W) return 1'b0;
      for (int i = hist.size() - PAT_W; i < hist.size(); i++) v = {v[PAT_W-2:0], hist[i]};
      return v == m_pat;
   endfunction
   task automatic do_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      hist.delete();
      m_cnt = 0;
      m_sc = 0;
      fresh = 1'b1;
      last_tmo = 1'b0;
      chk("start_busy", bus.busy_o, 1'b1);
      chk("start_cnt", bus.match_cnt_o, 0);
      chk("start_tmo", bus.timeout_o, 1'b0);
   endtask
   task automatic do_stop();
      bus.stop_i = 1'b1;
      step();
      bus.stop_i = 1'b0;
      chk("stop_busy", bus.busy_o, 1'b0);
      chk("stop_match", bus.match_o, 1'b0);
      chk("stop_tmo", bus.timeout_o, 1'b0);
   endtask
   task automatic load_pattern(input logic [PAT_W-1:0] p);
      bus.cfg_pattern_i = p;
      bus.cfg_we_i = 1'b1;
      step();
      bus.cfg_we_i = 1'b0;
      m_pat = p;
   endtask
   // one bit per tick; outcome of tick T is observed in cycle T+2
   task automatic send_bit(input logic b);
      int  w = 0;
      bit  em, et;
      bus.din_i = b;
      while (!bus.tick_o && w < 20) begin
         step();
         w++;
      end
      chk("tick_gap", 16'(w), 16'(fresh ? TICK_DIV - 1 : TICK_DIV - 2));
      if (!bus.tick_o) return;
      fresh = 1'b0;
      step();
      chk("match_early", bus.match_o, 1'b0);
      step();
      hist.push_back(b);
      m_sc++;
      em = model_match();
      et = !em && m_sc == MAX_S;
      chk("match", bus.match_o, em);
      chk("timeout", bus.timeout_o, et);
      chk("busy", bus.busy_o, !et);
      if (em) begin
         if (m_cnt < CNT_MAX) m_cnt++;
         m_sc = 0;
`ifndef PMC_OVERLAP_EN
         hist.delete();
`endif
      end
      chk("match_cnt", bus.match_cnt_o, 16'(m_cnt));
      last_tmo = et;
   endtask
   task automatic send_word(input logic [PAT_W-1:0] v);
      for (int i = PAT_W - 1; i >= 0; i--) send_bit(v[i]);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [PAT_W-1:0] chunk;
      int w;
      bus.cfg_we_i = 1'b0;
      bus.cfg_pattern_i = '0;
      bus.start_i = 1'b0;
      bus.stop_i = 1'b0;
      bus.din_i = 1'b0;
      step();
      step();
      chk("rst_tick", bus.tick_o, 1'b0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_match", bus.match_o, 1'b0);
      chk("rst_tmo", bus.timeout_o, 1'b0);
      chk("rst_cnt", bus.match_cnt_o, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("idle_tick", bus.tick_o, 1'b0);
         chk("idle_busy", bus.busy_o, 1'b0);
      end
      do_start();
      send_word(4'b1101);
      chk("first_cnt", bus.match_cnt_o, 1);
      step();
      chk("hit_one_cycle", bus.match_o, 1'b0);
      chk("hit_busy", bus.busy_o, 1'b1);
      do_stop();
      do_start();
      foreach (chunk[i]) chunk[i] = 1'b0;
      send_word(4'b1101);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("overlap_cnt", bus.match_cnt_o, OVL_CNT);
      do_stop();
      do_start();
      send_word(4'b1101);
      for (int i = 0; i < MAX_S; i++) send_bit(1'b0);
      chk("tmo_reached", bus.timeout_o, 1'b1);
      chk("tmo_cnt_held", bus.match_cnt_o, 1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("tmo_no_tick", bus.tick_o, 1'b0);
         chk("tmo_level", bus.timeout_o, 1'b1);
      end
      do_start();
      for (int i = 0; i < 5; i++) send_word(4'b1101);
      chk("sat_cnt", bus.match_cnt_o, CNT_MAX);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      bus.din_i = 1'b1;
      w = 0;
      while (!bus.tick_o && w < 20) begin
         step();
         w++;
      end
      chk("stop_tick_seen", bus.tick_o, 1'b1);
      step();
      bus.stop_i = 1'b1;
      step();
      bus.stop_i = 1'b0;
      chk("stop_drop_match", bus.match_o, 1'b0);
      chk("stop_drop_busy", bus.busy_o, 1'b0);
      step();
      chk("stop_drop_match2", bus.match_o, 1'b0);
      chk("stop_drop_tick", bus.tick_o, 1'b0);
      do_start();
      bus.cfg_pattern_i = 4'b1001;
      bus.cfg_we_i = 1'b1;
      send_word(4'b1101);
      bus.cfg_we_i = 1'b0;
      chk("cfg_ignored", bus.match_cnt_o, 1);
      do_stop();
      load_pattern(4'b1001);
      do_start();
      send_word(4'b1001);
      chk("cfg_loaded", bus.match_cnt_o, 1);
      for (int r = 0; r < 6; r++) begin
         do_stop();
         load_pattern(PAT_W'($urandom_range(1, (1 << PAT_W) - 1)));
         do_start();
         for (int c = 0; c < 8; c++) begin
            chunk = $urandom_range(0, 1) != 0 ? m_pat : PAT_W'($urandom);
            for (int i = PAT_W - 1; i >= 0; i--) begin
               send_bit(chunk[i]);
               if (last_tmo) do_start();
            end
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
